// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority pick: first unmasked request scanning from ptr upward, modulo 4.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic [1:0] pick_idx,
    output logic       pick_any
);

    logic [3:0] avail;
    logic [1:0] cand;

    // mask bits are requesters excluded from this pick (the current owner on preempt)
    always_comb begin
        avail    = req & ~mask;
        pick_idx = '0;
        pick_any = 1'b0;
        cand     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = ptr + IDX_W'(off);
            if (!pick_any && avail[cand]) begin
                pick_any = 1'b1;
                pick_idx = cand;
            end
        end
    end

endmodule

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with grant hold and bounded tenure.
module arb_rr_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [3:0] CNT_CAP      = HOLD_LIMITED ? 4'(MAX_HOLD) : 4'd15;

    state_t     state, state_d;
    logic [1:0] ptr, ptr_d;
    logic [3:0] cnt, cnt_d;
    logic [3:0] gnt_d;
    logic [1:0] gnt_idx_d;

    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic [3:0] pick_oh;
    logic       preempt;

    // While busy the scan starts just past the owner, which is also excluded;
    // owner exclusion is harmless on release since its request is already low.
    assign pick_ptr = (state == ST_BUSY) ? gnt_idx + 2'd1 : ptr;
    assign pick_oh  = 4'b0001 << pick_idx;
    assign preempt  = HOLD_LIMITED && (cnt == CNT_CAP) && (|(req & ~gnt));

    rr_pick_4 u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask     (gnt),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        cnt_d     = cnt;
        gnt_d     = gnt;
        gnt_idx_d = gnt_idx;
        case (state)
            ST_IDLE: begin
                if (en && pick_any) begin
                    state_d   = ST_BUSY;
                    gnt_d     = pick_oh;
                    gnt_idx_d = onehot2idx(pick_oh);
                    cnt_d     = 4'd1;
                end
            end
            ST_BUSY: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    cnt_d     = '0;
                end else if (!req[gnt_idx] || preempt) begin
                    ptr_d = gnt_idx + 2'd1;
                    if (pick_any) begin
                        gnt_d     = pick_oh;
                        gnt_idx_d = onehot2idx(pick_oh);
                        cnt_d     = 4'd1;
                    end else begin
                        state_d   = ST_IDLE;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        cnt_d     = '0;
                    end
                end else if (cnt != CNT_CAP) begin
                    cnt_d = cnt + 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
            gnt     <= gnt_d;
            gnt_idx <= gnt_idx_d;
        end
    end

    assign gnt_valid = (state == ST_BUSY);

endmodule

// File: tb/tb_arb_rr_4.sv
// Scoreboard bench for arb_rr_4 (MAX_HOLD=3) driven by hand-computed directed vectors.
module tb_arb_rr_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        int         step;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   stepNum    = 0;

    arb_rr_4 #(.MAX_HOLD(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // Drive one input vector per cycle and queue the outputs required after the next edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] rq,
                                 input logic [3:0] expGnt, input int n = 1);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = r;
            en  = e;
            req = rq;
            stepNum++;
            x.gnt   = expGnt;
            x.valid = (expGnt != 4'b0000);
            case (expGnt)
                4'b0010: x.idx = 2'd1;
                4'b0100: x.idx = 2'd2;
                4'b1000: x.idx = 2'd3;
                default: x.idx = 2'd0;
            endcase
            x.step = stepNum;
            expQ.push_back(x);
        end
    endtask

    task automatic checkOutput(input exp_t x);
        compared++;
        if (gnt !== x.gnt || gnt_idx !== x.idx || gnt_valid !== x.valid) begin
            mismatched++;
            $display("[TB] FAIL step%0d: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                     x.step, gnt, gnt_idx, gnt_valid, x.gnt, x.idx, x.valid);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput(x);
            end
        end
    end

    initial begin : stimulus
        // reset, then a single request and its release
        applyStimulus(1, 1, 4'b1111, 4'b0000, 2);
        applyStimulus(0, 1, 4'b0100, 4'b0100);
        applyStimulus(0, 1, 4'b0000, 4'b0000);
        applyStimulus(1, 1, 4'b0000, 4'b0000);

        // fairness: each owner drops for one cycle after two cycles of tenure
        applyStimulus(0, 1, 4'b1111, 4'b0001, 2);
        applyStimulus(0, 1, 4'b1110, 4'b0010);
        applyStimulus(0, 1, 4'b1111, 4'b0010);
        applyStimulus(0, 1, 4'b1101, 4'b0100);
        applyStimulus(0, 1, 4'b1111, 4'b0100);
        applyStimulus(0, 1, 4'b1011, 4'b1000);
        applyStimulus(0, 1, 4'b1111, 4'b1000);
        applyStimulus(0, 1, 4'b0111, 4'b0001);
        applyStimulus(0, 1, 4'b0000, 4'b0000);

        // preempt after exactly three cycles of tenure
        applyStimulus(1, 1, 4'b0000, 4'b0000);
        applyStimulus(0, 1, 4'b0011, 4'b0001, 3);
        applyStimulus(0, 1, 4'b0011, 4'b0010, 3);
        applyStimulus(0, 1, 4'b0011, 4'b0001, 2);
        applyStimulus(0, 1, 4'b0000, 4'b0000);

        // lone holder never preempted; saturated counter preempts at once
        applyStimulus(0, 1, 4'b1000, 4'b1000, 20);
        applyStimulus(0, 1, 4'b1001, 4'b0001);
        applyStimulus(0, 1, 4'b0000, 4'b0000);

        // enable gating keeps ptr (ptr=1 here)
        applyStimulus(0, 1, 4'b0100, 4'b0100, 2);
        applyStimulus(0, 0, 4'b0100, 4'b0000);
        applyStimulus(0, 1, 4'b0100, 4'b0100);
        applyStimulus(0, 0, 4'b1111, 4'b0000);
        applyStimulus(0, 1, 4'b1111, 4'b0010);

        // owner 1 holding with ptr=2, then reset mid-grant
        applyStimulus(0, 1, 4'b1101, 4'b0100);
        applyStimulus(0, 0, 4'b1101, 4'b0000);
        applyStimulus(0, 1, 4'b0010, 4'b0010, 2);
        applyStimulus(1, 1, 4'b1111, 4'b0000);
        applyStimulus(0, 1, 4'b1111, 4'b0001);
        applyStimulus(0, 1, 4'b0000, 4'b0000);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        if (expQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/arb_rr_4.md
# arb_rr_4

Four-requester round-robin arbiter with grant hold and bounded tenure. It owns one shared resource, such as a bus port or a shared encoder/ALU, and issues a one-hot grant plus its 2-bit encoded index. A grant is held while the owner keeps requesting. The owner is forcibly rotated after MAX_HOLD cycles when others are waiting. It sits between the requesting units and the shared datapath's select/enable input.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant while others request. 0 = unlimited. Legal range 0..15.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; low forces release and idle.
- req  input  4  request vector, bit i = requester i.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- gnt_idx  output  2  binary index of the granted requester; 0 when idle.
- gnt_valid  output  1  high when exactly one grant bit is set.

## Operation
- Reset values:
  - state=IDLE, gnt=4'b0000, gnt_idx=0, gnt_valid=0.
  - Priority pointer ptr=0, hold counter cnt=0.
- Pick function: the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If en && |req: grant the picked requester, go to BUSY, cnt<=1.
  - Otherwise stay in IDLE.
- BUSY, evaluated in priority order, where owner = gnt_idx:
  1. en==0: release, go to IDLE, ptr unchanged, cnt<=0.
  2. req[owner]==0: release. ptr<=owner+1 (wraps 3->0). Re-pick combinationally using the new ptr against the current req:
     - If any request remains, grant it in the same edge (no bubble), cnt<=1.
     - Otherwise go to IDLE.
  3. MAX_HOLD!=0 && cnt==MAX_HOLD && (req & ~gnt)!=0: preempt. ptr<=owner+1, re-pick excluding owner, cnt<=1.
  4. Otherwise hold the grant. cnt<=cnt+1, saturating at 15 (and at MAX_HOLD when MAX_HOLD!=0).
- ptr changes only on release or preempt, never on an IDLE->BUSY grant.
- gnt, gnt_idx and gnt_valid are always mutually consistent. gnt_valid == (state==BUSY).
- A requester that keeps requesting alone is never preempted.

## Timing
- All outputs come from registers. There is no combinational path from req or en to any output.
- Latency:
  - req rising at edge N (sampled) produces gnt visible after edge N, i.e. one cycle.
  - Owner drops req, sampled at edge N: the new grant, or idle, is visible after edge N.
- Simultaneous release and other requests: the handover is seamless, with exactly one cycle per owner boundary and no idle cycle.
- Preempt: the owner holds exactly MAX_HOLD cycles. The next owner is visible on cycle MAX_HOLD+1.
- rst mid-grant: all outputs are 0 after the reset edge and ptr=0. rst has priority over en and req.
- en low for one cycle: the grant drops for at least one cycle. Re-grant follows the normal IDLE rule with the retained ptr.

## Structure
- Package arb_pkg:
  - State localparams ST_IDLE=1'b0 and ST_BUSY=1'b1.
  - N_REQ=4 and IDX_W=2.
  - Function onehot2idx (4-to-2 encode).
- Sub-module rr_pick_4 (combinational):
  - Inputs: req[3:0], ptr[1:0], mask[3:0].
  - Outputs: pick_idx[1:0], pick_any.
  - Rotating-priority scan implemented as a for loop over offsets 0..3.
- Top level contains the state register, ptr, cnt and output registers only.

## Test plan
- Reset then single request: assert rst 2 cycles, then req=4'b0100. Required: gnt=4'b0100, gnt_idx=2, gnt_valid=1 one cycle after sampling; all outputs 0 during reset.
- Round-robin fairness: req=4'b1111 held, each owner drops req for one cycle after 2 cycles of tenure, then re-raises. Required: grant order 0,1,2,3,0 with no idle cycles between owners.
- Preempt, MAX_HOLD=3: req=4'b0011 held constantly. Required: idx 0 for 3 cycles, idx 1 for 3 cycles, idx 0 again; each owner's tenure is exactly 3 cycles.
- Lone holder, MAX_HOLD=3: req=4'b1000 held 20 cycles. Required: gnt=4'b1000 continuously; cnt saturates; no drop.
- Enable gating: granted owner 2 holding, en=0 for 1 cycle. Required: gnt=0, gnt_valid=0 the next cycle. With en=1 and req=4'b0100 unchanged, owner 2 is re-granted, because ptr is unchanged.
- Reset mid-grant: owner 1 holding with ptr=2, then rst=1 for one cycle. Required: outputs 0. With req=4'b1111, the next grant is idx 0 (ptr=0).
